// File: rtl/soup_farm.sv
// soup_farm: multi-core trial dispatcher and hit-record collector for the soup search.
// Define SOUP_FARM_STATS_EN to add the hit_count and fifo_hwm status outputs.
module soup_farm #(
  parameter int NCORE = 4,
  parameter int INIT  = 20,
  parameter int RW    = INIT*INIT+32,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  brk,
  input  logic                  start,
  input  logic [31:0]           num_init,
  output logic [NCORE-1:0]      go,
  output logic [31:0]           go_idx,
  input  logic [NCORE-1:0]      core_done,
  input  logic [NCORE-1:0]      core_hit,
  input  logic [NCORE*RW-1:0]   core_data,
  output logic [NCORE-1:0]      core_ack,
  output logic                  out_valid,
  output logic [RW-1:0]         out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  fin
`ifdef SOUP_FARM_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [$clog2(DEPTH):0] fifo_hwm
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RRW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [31:0]       r_target, r_issued, r_completed;
  logic [NCORE-1:0]  r_corebusy;
  logic [RRW-1:0]    r_rr;
  logic [RW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;

  logic [NCORE-1:0]  w_req, w_grant, w_go_sel;
  logic              w_grant_vld, w_any_idle, w_hit, w_full, w_run;
  logic              w_do_ack, w_do_go, w_push, w_pop;
  logic [RRW:0]      w_sum, w_rnext;
  logic [RRW-1:0]    w_gidx;
  logic [RW-1:0]     w_rec;
  logic [AW:0]       w_cnt_rem, w_cnt_next;

  // Round-robin search over busy cores reporting done, starting at r_rr
  always_comb begin
    w_req       = core_done & r_corebusy;
    w_grant_vld = 1'b0;
    w_gidx      = '0;
    w_sum       = '0;
    for (int k = 0; k < NCORE; k++) begin
      w_sum = {1'b0, r_rr} + (RRW+1)'(k);
      if (w_sum >= (RRW+1)'(NCORE)) w_sum = w_sum - (RRW+1)'(NCORE);
      if (!w_grant_vld && w_req[w_sum[RRW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_gidx      = w_sum[RRW-1:0];
      end
    end
    w_grant = w_grant_vld ? (NCORE'(1) << w_gidx) : '0;
    w_rnext = {1'b0, w_gidx} + (RRW+1)'(1);
    if (w_rnext >= (RRW+1)'(NCORE)) w_rnext = '0;
    w_hit = |(w_grant & core_hit);
    w_rec = '0;
    for (int k = 0; k < NCORE; k++) begin
      if (w_grant[k]) w_rec = core_data[k*RW +: RW];
    end
  end

  always_comb begin
    w_go_sel   = '0;
    w_any_idle = 1'b0;
    for (int k = 0; k < NCORE; k++) begin
      if (!w_any_idle && !r_corebusy[k]) begin
        w_go_sel[k] = 1'b1;
        w_any_idle  = 1'b1;
      end
    end
  end

  // A hit that finds the FIFO full is neither acked nor granted, so it retries next cycle
  assign w_run      = (r_state == S_RUN) && (r_completed != r_target);
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_do_ack   = w_run && w_grant_vld && !(w_hit && w_full);
  assign w_push     = w_do_ack && w_hit && !brk;
  assign w_do_go    = w_run && (r_issued < r_target) && w_any_idle;
  assign w_pop      = out_valid && out_ready;
  assign w_cnt_rem  = r_count - (AW+1)'(w_pop);
  assign w_cnt_next = w_cnt_rem + (AW+1)'(w_push);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_corebusy  <= '0;
      r_rr        <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      go          <= '0;
      go_idx      <= '0;
      core_ack    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      fin         <= 1'b0;
    end else if (brk) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_corebusy  <= '0;
      r_rr        <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      go          <= '0;
      core_ack    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      fin         <= 1'b0;
    end else begin
      go       <= '0;
      core_ack <= '0;
      fin      <= 1'b0;
      if (w_do_go) begin
        go       <= w_go_sel;
        go_idx   <= r_issued;
        r_issued <= r_issued + 32'd1;
      end
      if (w_do_ack) begin
        core_ack    <= w_grant;
        r_completed <= r_completed + 32'd1;
        r_rr        <= w_rnext[RRW-1:0];
      end
      r_corebusy <= (r_corebusy & ~(w_do_ack ? w_grant : '0)) | (w_do_go ? w_go_sel : '0);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target    <= num_init;
            r_issued    <= '0;
            r_completed <= '0;
            if (num_init == 32'd0) begin
              fin <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_completed == r_target) begin
            r_state <= S_IDLE;
            fin     <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Head register reflects entries present before this edge, minus any pop
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr    <= r_rptr + AW'(w_pop);
      r_count   <= w_cnt_next;
      out_valid <= (w_cnt_rem != '0);
      out_data  <= r_mem[r_rptr + AW'(w_pop)];
    end
  end

`ifdef SOUP_FARM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
      fifo_hwm  <= '0;
    end else if (brk) begin
      hit_count <= '0;
      fifo_hwm  <= '0;
    end else begin
      if (r_state == S_IDLE && start) hit_count <= '0;
      else if (w_push)                hit_count <= hit_count + 32'd1;
      if (w_cnt_next > fifo_hwm) fifo_hwm <= w_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_soup_farm.sv
// Directed bench for soup_farm: cycle-exact vector table plus core-model driven sequences.
module tb_soup_farm;
  localparam int NCORE = 4;
  localparam int INIT  = 4;
  localparam int RW    = INIT*INIT+32;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                brk = 1'b0;
  logic                start = 1'b0;
  logic [31:0]         num_init = '0;
  logic [NCORE-1:0]    core_done = '0;
  logic [NCORE-1:0]    core_hit = '0;
  logic [NCORE*RW-1:0] core_data = '0;
  logic                out_ready = 1'b0;
  logic [NCORE-1:0]    go, core_ack;
  logic [31:0]         go_idx;
  logic                out_valid, busy, fin;
  logic [RW-1:0]       out_data;
`ifdef SOUP_FARM_STATS_EN
  logic [31:0]         hit_count;
  logic [$clog2(DEPTH):0] fifo_hwm;
`endif

  soup_farm #(.NCORE(NCORE), .INIT(INIT), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .brk(brk), .start(start), .num_init(num_init),
    .go(go), .go_idx(go_idx), .core_done(core_done), .core_hit(core_hit),
    .core_data(core_data), .core_ack(core_ack), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .fin(fin)
`ifdef SOUP_FARM_STATS_EN
    , .hit_count(hit_count), .fifo_hwm(fifo_hwm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [31:0] num;
    logic [3:0]  done;
    logic [3:0]  go;
    logic [31:0] idx;
    logic [3:0]  ack;
    logic        busy;
    logic        fin;
  } vec_t;

  vec_t vq[$];
  int n_tests = 0;
  int n_fail  = 0;

  int           cnt [NCORE];
  logic [31:0]  cidx [NCORE];
  logic [NCORE-1:0] cdone;
  logic         model_en = 1'b0;
  logic         hit_mode = 1'b0;
  logic         rdy_mode = 1'b0;
  int           lat = 3;

  int           go_cnt, ack_cnt, fin_cnt, fin_at_ack, multi_err, g0;
  logic         ov_seen;
  logic [31:0]  go_q[$];
  logic [RW-1:0] rx_q[$];

  function automatic logic [RW-1:0] rec(input logic [31:0] i);
    logic [INIT*INIT-1:0] p;
    p = i[INIT*INIT-1:0] ^ 16'hA5C3;
    return {p, i};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input int n, input logic [3:0] d, input logic [3:0] g,
                     input int idx, input logic [3:0] a, input logic b, input logic f);
    vec_t v;
    v.start = s; v.num = n; v.done = d; v.go = g; v.idx = idx; v.ack = a; v.busy = b; v.fin = f;
    vq.push_back(v);
  endtask

  task automatic clear_obs();
    go_cnt = 0; ack_cnt = 0; fin_cnt = 0; fin_at_ack = -1; multi_err = 0; ov_seen = 1'b0;
    go_q.delete(); rx_q.delete();
  endtask

  task automatic clear_model();
    for (int k = 0; k < NCORE; k++) begin cnt[k] = 0; cidx[k] = '0; end
    cdone = '0; core_done = '0; core_hit = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (go != '0) begin
      go_cnt++; go_q.push_back(go_idx);
      if (!$onehot(go)) multi_err++;
    end
    if (core_ack != '0) begin
      ack_cnt++;
      if (!$onehot(core_ack)) multi_err++;
    end
    if ((go & core_ack) != '0) multi_err++;
    if (fin) begin fin_cnt++; fin_at_ack = ack_cnt; end
    if (out_valid) ov_seen = 1'b1;
    if (model_en) begin
      for (int k = 0; k < NCORE; k++) begin
        if (core_ack[k]) cdone[k] = 1'b0;
        if (go[k]) begin
          cidx[k] = go_idx; cnt[k] = lat;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) cdone[k] = 1'b1;
        end
        core_data[k*RW +: RW] = rec(cidx[k]);
      end
      core_done = cdone;
      core_hit  = hit_mode ? cdone : '0;
      out_ready = rdy_mode;
      if (out_valid && out_ready) rx_q.push_back(out_data);
    end
  endtask

  task automatic run_until_fin(input int budget, input string name);
    int f0;
    f0 = fin_cnt;
    for (int i = 0; i < budget && fin_cnt == f0; i++) tick();
    check(name, fin_cnt - f0, 1);
  endtask

  initial begin
    clear_obs();
    clear_model();
    #12;
    check("reset_outputs", {go, go_idx, core_ack, out_valid, busy, fin}, '0);
    check("reset_out_data", out_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // start, num, done | go, go_idx, ack, busy, fin
    add(1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 0);
    add(1, 4, 4'h0, 4'h0, 0, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h1, 0, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h2, 1, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h4, 2, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h8, 3, 4'h0, 1, 0);
    add(0, 0, 4'hF, 4'h0, 3, 4'h1, 1, 0);
    add(0, 0, 4'hE, 4'h0, 3, 4'h2, 1, 0);
    add(0, 0, 4'hC, 4'h0, 3, 4'h4, 1, 0);
    add(0, 0, 4'h8, 4'h0, 3, 4'h8, 1, 0);
    add(0, 0, 4'h0, 4'h0, 3, 4'h0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 3, 4'h0, 0, 0);
    add(1, 4, 4'h0, 4'h0, 3, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h1, 0, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h2, 1, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h4, 2, 4'h0, 1, 0);
    add(0, 0, 4'h0, 4'h8, 3, 4'h0, 1, 0);
    add(0, 0, 4'hA, 4'h0, 3, 4'h2, 1, 0);
    add(0, 0, 4'h8, 4'h0, 3, 4'h8, 1, 0);
    add(0, 0, 4'h5, 4'h0, 3, 4'h1, 1, 0);
    add(0, 0, 4'h4, 4'h0, 3, 4'h4, 1, 0);
    add(0, 0, 4'h0, 4'h0, 3, 4'h0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 3, 4'h0, 0, 0);
    foreach (vq[i]) begin
      start = vq[i].start; num_init = vq[i].num; core_done = vq[i].done;
      core_hit = '0; out_ready = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {go, go_idx, core_ack, busy, fin, out_valid},
            {vq[i].go, vq[i].idx, vq[i].ack, vq[i].busy, vq[i].fin, 1'b0});
    end
    start = 1'b0; core_done = '0;

    // Ten trials, no hits
    model_en = 1'b1; clear_obs(); clear_model(); hit_mode = 1'b0; rdy_mode = 1'b1;
    num_init = 10; start = 1'b1; tick(); start = 1'b0;
    run_until_fin(300, "t2_fin");
    repeat (4) tick();
    check("t2_go_cnt", go_cnt, 10);
    check("t2_go_q_size", go_q.size(), 10);
    for (int i = 0; i < go_q.size(); i++) check($sformatf("t2_go_idx%0d", i), go_q[i], i);
    check("t2_fin_once", fin_cnt, 1);
    check("t2_no_valid", ov_seen, 1'b0);
    check("t2_busy_end", busy, 1'b0);

    // Six hits against a 4-deep FIFO with the consumer stalled
    clear_obs(); clear_model(); hit_mode = 1'b1; rdy_mode = 1'b0;
    num_init = 6; start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    check("t3_acks_while_full", ack_cnt, 4);
    check("t3_done_held", $countones(core_done), 2);
    check("t3_valid", out_valid, 1'b1);
    check("t3_no_fin_yet", fin_cnt, 0);
    check("t3_busy", busy, 1'b1);
    rdy_mode = 1'b1;
    run_until_fin(200, "t3_fin");
    check("t3_fin_after_6th_ack", fin_at_ack, 6);
    for (int i = 0; i < 50 && rx_q.size() < 6; i++) tick();
    check("t3_rx_cnt", rx_q.size(), 6);
    for (int i = 0; i < rx_q.size(); i++) check($sformatf("t3_rec%0d", i), rx_q[i], rec(i));
    check("t3_fin_once", fin_cnt, 1);
`ifdef SOUP_FARM_STATS_EN
    check("t3_hit_count", hit_count, 6);
    check("t3_fifo_hwm", fifo_hwm, DEPTH);
`endif

    // Break with three records queued
    clear_obs(); clear_model(); hit_mode = 1'b1; rdy_mode = 1'b0;
    num_init = 20; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 100 && ack_cnt < 3; i++) tick();
    check("brk_three_acked", ack_cnt, 3);
    check("brk_valid_before", out_valid, 1'b1);
    brk = 1'b1; tick(); brk = 1'b0;
    check("brk_valid_after", out_valid, 1'b0);
    check("brk_busy_after", busy, 1'b0);
    clear_model();
    g0 = go_cnt;
    repeat (5) tick();
    check("brk_no_fin", fin_cnt, 0);
    check("brk_no_go", go_cnt, g0);
    clear_obs(); hit_mode = 1'b0; rdy_mode = 1'b1;
    num_init = 2; start = 1'b1; tick(); start = 1'b0;
    run_until_fin(100, "brk_restart_fin");
    check("brk_restart_go_cnt", go_cnt, 2);
    if (go_q.size() == 2) begin
      check("brk_restart_idx0", go_q[0], 0);
      check("brk_restart_idx1", go_q[1], 1);
    end else begin
      check("brk_restart_q_size", go_q.size(), 2);
    end
    check("no_multi_or_reissue", multi_err, 0);

    // Asynchronous reset mid-run
    clear_obs(); clear_model(); hit_mode = 1'b0; rdy_mode = 1'b1;
    num_init = 10; start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check("rst_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    #2;
    check("rst_outputs", {go, go_idx, core_ack, out_valid, busy, fin}, '0);
    check("rst_out_data", out_data, '0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    g0 = go_cnt;
    repeat (10) tick();
    check("rst_no_go", go_cnt, g0);
    check("rst_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
